// File: rtl/hermes_switch_control.sv
// -----------------------------------------------------------------------------
// hermes_switch_control
// Routing and arbitration control for one Hermes mesh NoC router. Picks one
// pending header request by round-robin, computes its XY output port,
// allocates that output, and maintains the crossbar connection tables.
// An output is released on the falling edge of the owning input's sending_i.
//
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   req_i      per-input header request
//   header_i   per-input target address (upper half X, lower half Y)
//   sending_i  per-input "packet in flight" flag
//   ack_o      one-cycle grant pulse to the selected input
//   outport_o  per-input output port it drives (EAST=0..LOCAL=4)
//   inport_o   per-output input connected to it
//   out_en_o   per-output allocation valid
// -----------------------------------------------------------------------------
module hermes_switch_control #(
   parameter int                    NPORT      = 5,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] ADDRESS    = 8'h00
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NPORT-1:0]                      req_i,
   input  logic [NPORT-1:0][ADDR_WIDTH-1:0]      header_i,
   input  logic [NPORT-1:0]                      sending_i,
   output logic [NPORT-1:0]                      ack_o,
   output logic [NPORT-1:0][2:0]                 outport_o,
   output logic [NPORT-1:0][2:0]                 inport_o,
   output logic [NPORT-1:0]                      out_en_o
);

   localparam logic [2:0] P_EAST  = 3'd0;
   localparam logic [2:0] P_WEST  = 3'd1;
   localparam logic [2:0] P_NORTH = 3'd2;
   localparam logic [2:0] P_SOUTH = 3'd3;
   localparam logic [2:0] P_LOCAL = 3'd4;

   localparam int HALF = ADDR_WIDTH / 2;
   localparam logic [HALF-1:0] LX = ADDRESS[ADDR_WIDTH-1:HALF];
   localparam logic [HALF-1:0] LY = ADDRESS[HALF-1:0];

   localparam logic [NPORT-1:0] ONE_HOT0 = {{(NPORT-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARB   = 2'd1,
      S_ROUTE = 2'd2,
      S_GRANT = 2'd3
   } state_t;

   state_t                  state_q;
   logic [2:0]              ptr_q;
   logic [2:0]              sel_q;
   logic [2:0]              tgt_q;
   logic [NPORT-1:0]        out_en_q;
   logic [NPORT-1:0]        out_en_d;
   logic [NPORT-1:0][2:0]   outport_q;
   logic [NPORT-1:0][2:0]   inport_q;
   logic [NPORT-1:0]        sending_q;

   logic [2:0]              pick_s;
   logic [2:0]              route_s;
   logic                    grant_s;
   logic [NPORT-1:0]        release_s;

   // First requester strictly after ptr, wrapping; returns ptr if none.
   function automatic logic [2:0] rr_pick(input logic [2:0] ptr,
                                          input logic [NPORT-1:0] req);
      logic [2:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 1; k <= NPORT; k++) begin
         idx = 3'((32'(ptr) + k) % NPORT);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

   // XY routing: resolve X first, then Y, else deliver locally.
   function automatic logic [2:0] xy_route(input logic [ADDR_WIDTH-1:0] hdr);
      logic [HALF-1:0] tx;
      logic [HALF-1:0] ty;
      tx = hdr[ADDR_WIDTH-1:HALF];
      ty = hdr[HALF-1:0];
      if (tx > LX) begin
         xy_route = P_EAST;
      end else if (tx < LX) begin
         xy_route = P_WEST;
      end else if (ty > LY) begin
         xy_route = P_NORTH;
      end else if (ty < LY) begin
         xy_route = P_SOUTH;
      end else begin
         xy_route = P_LOCAL;
      end
   endfunction

   assign pick_s  = rr_pick(ptr_q, req_i);
   assign route_s = xy_route(header_i[sel_q]);

   // Grant uses the pre-release allocation, so a same-edge release of the
   // target output refuses the grant; the request retries next round.
   assign grant_s = (state_q == S_GRANT) && req_i[sel_q] && !out_en_q[tgt_q];

   // Ack is combinational so an asynchronous reset removes it immediately.
   assign ack_o = grant_s ? (ONE_HOT0 << sel_q) : {NPORT{1'b0}};

   // Release detection: falling sending_i on an input that owns its output.
   always_comb begin
      release_s = {NPORT{1'b0}};
      for (int i = 0; i < NPORT; i++) begin
         if (sending_q[i] && !sending_i[i] &&
             out_en_q[outport_q[i]] && (inport_q[outport_q[i]] == 3'(i))) begin
            release_s[outport_q[i]] = 1'b1;
         end else begin
            release_s = release_s;
         end
      end
   end

   // Next allocation vector: releases clear, a grant sets its target bit.
   always_comb begin
      out_en_d = out_en_q & ~release_s;
      if (grant_s) begin
         out_en_d = out_en_d | (ONE_HOT0 << tgt_q);
      end else begin
         out_en_d = out_en_d;
      end
   end

   // Control FSM plus allocation and connection-table registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         ptr_q     <= P_LOCAL;
         sel_q     <= 3'd0;
         tgt_q     <= 3'd0;
         out_en_q  <= {NPORT{1'b0}};
         outport_q <= {NPORT{3'b000}};
         inport_q  <= {NPORT{3'b000}};
         sending_q <= {NPORT{1'b0}};
      end else begin
         sending_q <= sending_i;
         out_en_q  <= out_en_d;
         if (grant_s) begin
            outport_q[sel_q] <= tgt_q;
            inport_q[tgt_q]  <= sel_q;
         end else begin
            outport_q <= outport_q;
         end
         case (state_q)
            S_IDLE: begin
               if (|req_i) state_q <= S_ARB;
               else        state_q <= S_IDLE;
            end
            S_ARB: begin
               if (|req_i) begin
                  sel_q   <= pick_s;
                  ptr_q   <= pick_s;
                  state_q <= S_ROUTE;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ROUTE: begin
               tgt_q   <= route_s;
               state_q <= S_GRANT;
            end
            S_GRANT: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign out_en_o  = out_en_q;
   assign outport_o = outport_q;
   assign inport_o  = inport_q;

endmodule

// File: tb/tb_hermes_switch_control.sv
// -----------------------------------------------------------------------------
// tb_hermes_switch_control
// Directed self-checking bench for hermes_switch_control at ADDRESS=8'h11.
// A route table drives single-header transactions from LOCAL; hand-written
// sequences cover contention/release, reset during grant and round-robin.
// -----------------------------------------------------------------------------
module tb_hermes_switch_control;

   logic            clk = 1'b0;
   logic            rst;
   logic [4:0]      req;
   logic [4:0][7:0] header;
   logic [4:0]      sending;
   logic [4:0]      ack_o;
   logic [4:0][2:0] outport_o;
   logic [4:0][2:0] inport_o;
   logic [4:0]      out_en_o;

   int checks = 0;
   int errors = 0;

   hermes_switch_control #(
      .NPORT      (5),
      .ADDR_WIDTH (8),
      .ADDRESS    (8'h11)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .header_i  (header),
      .sending_i (sending),
      .ack_o     (ack_o),
      .outport_o (outport_o),
      .inport_o  (inport_o),
      .out_en_o  (out_en_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] hdr;
      logic [2:0] port;
   } route_vec_t;

   route_vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Waits until ack_o[p] is seen; cyc = edges waited, or -1 on timeout.
   task automatic wait_ack(input int p, input int budget, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!ack_o[p] && cyc < budget);
      if (!ack_o[p]) cyc = -1;
   endtask

   task automatic release_port(input int p);
      sending[p] = 1'b1;
      tick();
      sending[p] = 1'b0;
      tick();
   endtask

   // Buffer protocol: sending_i only on an input that owns an allocated output.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 5; i++) begin
            if (sending[i] && !(out_en_o[outport_o[i]] && inport_o[outport_o[i]] == 3'(i))) begin
               errors++;
               $display("FAIL protocol: sending[%0d] high without allocation", i);
            end
         end
      end
   end

   initial begin
      int cyc;
      int nack;
      int ng;
      int pend;

      tbl[0] = '{hdr: 8'h31, port: 3'd0};
      tbl[1] = '{hdr: 8'h01, port: 3'd1};
      tbl[2] = '{hdr: 8'h12, port: 3'd2};
      tbl[3] = '{hdr: 8'h10, port: 3'd3};
      tbl[4] = '{hdr: 8'h11, port: 3'd4};

      rst = 1'b1; req = 5'b0; sending = 5'b0; header = '0;
      tick(); tick();
      check("rst_out_en", out_en_o, 5'b0);
      check("rst_ack", ack_o, 5'b0);
      check("rst_outport", outport_o, 15'h0);
      check("rst_inport", inport_o, 15'h0);
      rst = 1'b0;

      nack = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack_o != 5'b0) nack++;
      end
      check("idle_no_ack", nack, 0);
      check("idle_out_en", out_en_o, 5'b0);

      // Route table: one header from LOCAL each, released between headers.
      for (int v = 0; v < 5; v++) begin
         header[4] = tbl[v].hdr;
         req[4] = 1'b1;
         wait_ack(4, 12, cyc);
         check($sformatf("route%0d_latency", v), cyc, 3);
         tick();
         req[4] = 1'b0;
         check($sformatf("route%0d_ack_pulse", v), ack_o, 5'b0);
         check($sformatf("route%0d_outport", v), outport_o[4], tbl[v].port);
         check($sformatf("route%0d_inport", v), inport_o[tbl[v].port], 3'd4);
         check($sformatf("route%0d_out_en", v), out_en_o, 5'b00001 << tbl[v].port);
         release_port(4);
         check($sformatf("route%0d_release", v), out_en_o, 5'b0);
      end

      // Contention: WEST and NORTH both head for EAST, ptr=LOCAL.
      header[1] = 8'h21; header[2] = 8'h21;
      req[1] = 1'b1; req[2] = 1'b1;
      wait_ack(1, 12, cyc);
      check("cont_west_latency", cyc, 3);
      check("cont_ack_west_only", ack_o, 5'b00010);
      tick();
      req[1] = 1'b0;
      sending[1] = 1'b1;
      check("cont_out_en", out_en_o, 5'b00001);
      check("cont_inport0", inport_o[0], 3'd1);
      check("cont_outport1", outport_o[1], 3'd0);
      nack = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack_o[2]) nack++;
      end
      check("cont_north_blocked", nack, 0);
      sending[1] = 1'b0;
      tick();
      check("cont_release_edge", out_en_o, 5'b0);
      wait_ack(2, 12, cyc);
      check("cont_north_acked", ack_o, 5'b00100);
      tick();
      req[2] = 1'b0;
      check("cont_north_out_en", out_en_o, 5'b00001);
      check("cont_north_inport0", inport_o[0], 3'd2);
      check("cont_north_outport2", outport_o[2], 3'd0);
      release_port(2);
      check("cont_north_release", out_en_o, 5'b0);

      // Reset during S_GRANT with an existing allocation on LOCAL.
      header[4] = 8'h11;
      req[4] = 1'b1;
      wait_ack(4, 12, cyc);
      tick();
      req[4] = 1'b0;
      check("rstg_pre_alloc", out_en_o, 5'b10000);
      header[2] = 8'h21;
      req[2] = 1'b1;
      wait_ack(2, 12, cyc);
      check("rstg_ack_before", ack_o, 5'b00100);
      rst = 1'b1;
      #1;
      check("rstg_ack_async", ack_o, 5'b0);
      check("rstg_out_en_async", out_en_o, 5'b0);
      check("rstg_inport_async", inport_o, 15'h0);
      req = 5'b0;
      tick();
      rst = 1'b0;
      tick();

      // Round-robin: all inputs request distinct outputs (input i -> port i).
      header[0] = 8'h21; header[1] = 8'h01; header[2] = 8'h12;
      header[3] = 8'h10; header[4] = 8'h11;
      req = 5'b11111;
      cyc = 0; ng = 0; pend = -1;
      while (ng < 5 && cyc < 60) begin
         tick();
         cyc++;
         if (pend >= 0) begin
            req[pend] = 1'b0;
            pend = -1;
         end
         if (ack_o != 5'b0) begin
            check($sformatf("rr_grant%0d_who", ng), ack_o, 5'b00001 << ng);
            check($sformatf("rr_grant%0d_cycle", ng), cyc, 3 + 4 * ng);
            for (int b = 0; b < 5; b++) if (ack_o[b]) pend = b;
            ng++;
         end
      end
      check("rr_all_granted", ng, 5);
      tick();
      if (pend >= 0) req[pend] = 1'b0;
      req = 5'b0;
      check("rr_out_en", out_en_o, 5'b11111);
      check("rr_inport", inport_o, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
      check("rr_outport", outport_o, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
